// File: rtl/fifo_1r1w_sync_flags.sv
// fifo_1r1w_sync_flags: single-clock 1-read/1-write FIFO with occupancy count,
// almost-full/almost-empty flags and synchronous flush.
// Optional feature macro: FIFO_SYNC_BYPASS_EN (zero-latency pass-through when empty).
// Read data comes from a registered read port addressed by the next read
// pointer, so pdata_o always shows the word at rd_ptr with no extra latency.
module fifo_1r1w_sync_flags #(
    parameter int width_p        = 32,
    parameter int depth_log2_p   = 4,
    parameter int almost_full_p  = (32'sd1 << depth_log2_p) - 32'sd1,
    parameter int almost_empty_p = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    flush_i,
    input  logic [width_p-1:0]      cdata_i,
    input  logic                    cvalid_i,
    output logic                    cready_o,
    output logic                    pvalid_o,
    output logic [width_p-1:0]      pdata_o,
    input  logic                    pready_i,
    output logic [depth_log2_p:0]   count_o,
    output logic                    almost_full_o,
    output logic                    almost_empty_o
);

    localparam int PTR_W_C = depth_log2_p + 1;
    localparam int DEPTH_C = 1 << depth_log2_p;
    localparam logic [PTR_W_C-1:0] PTR_ZERO_C = {PTR_W_C{1'b0}};
    localparam logic [PTR_W_C-1:0] PTR_ONE_C  = {{depth_log2_p{1'b0}}, 1'b1};
    localparam logic [PTR_W_C-1:0] AF_C       = PTR_W_C'(almost_full_p);
    localparam logic [PTR_W_C-1:0] AE_C       = PTR_W_C'(almost_empty_p);

    logic [PTR_W_C-1:0]      wr_ptr_r;
    logic [PTR_W_C-1:0]      rd_ptr_r;
    logic [PTR_W_C-1:0]      wr_ptr_nxt_s;
    logic [PTR_W_C-1:0]      rd_ptr_nxt_s;
    logic [depth_log2_p-1:0] wr_addr_s;
    logic [depth_log2_p-1:0] rd_addr_nxt_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    stored_valid_s;
    logic                    byp_s;
    logic                    push_s;
    logic                    pop_s;
    logic [width_p-1:0]      mem_r [DEPTH_C];
    logic [width_p-1:0]      pdata_r;

    // Occupancy and full/empty derive from the extra pointer MSB.
    assign full_s  = (wr_ptr_r[depth_log2_p] != rd_ptr_r[depth_log2_p]) &&
                     (wr_ptr_r[depth_log2_p-1:0] == rd_ptr_r[depth_log2_p-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign count_o = wr_ptr_r - rd_ptr_r;

    assign almost_full_o  = (count_o >= AF_C);
    assign almost_empty_o = (count_o <= AE_C);

    // cready_o only looks at stored state: a same-cycle pop never opens a slot.
    assign cready_o       = ~full_s & ~flush_i;
    assign stored_valid_s = ~empty_s & ~flush_i;

`ifdef FIFO_SYNC_BYPASS_EN
    // When empty, an incoming word is offered straight to the consumer.
    assign byp_s    = empty_s & cvalid_i & ~flush_i;
    assign pdata_o  = byp_s ? cdata_i : pdata_r;
`else
    assign byp_s    = 1'b0;
    assign pdata_o  = pdata_r;
`endif

    assign pvalid_o = stored_valid_s | byp_s;
    // A bypassed word taken in the same cycle is never stored.
    assign push_s   = cvalid_i & cready_o & ~(byp_s & pready_i);
    assign pop_s    = stored_valid_s & pready_i;

    assign wr_addr_s     = wr_ptr_r[depth_log2_p-1:0];
    assign rd_addr_nxt_s = rd_ptr_nxt_s[depth_log2_p-1:0];

    // Next-pointer logic; flush returns both pointers to zero.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (flush_i) begin
            wr_ptr_nxt_s = PTR_ZERO_C;
            rd_ptr_nxt_s = PTR_ZERO_C;
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE_C;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE_C;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
        end
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            wr_ptr_r <= PTR_ZERO_C;
            rd_ptr_r <= PTR_ZERO_C;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
        end
    end

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_addr_s] <= cdata_i;
        end
    end

    // Registered read port fed by the next read pointer, forwarding a
    // same-cycle write to that address so the output never goes stale.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            pdata_r <= {width_p{1'b0}};
        end else if (push_s && (wr_addr_s == rd_addr_nxt_s)) begin
            pdata_r <= cdata_i;
        end else begin
            pdata_r <= mem_r[rd_addr_nxt_s];
        end
    end

endmodule

// File: doc/fifo_1r1w_sync_flags.md
# fifo_1r1w_sync_flags

Single-clock, parametrised 1-read/1-write FIFO with occupancy count, programmable almost-full/almost-empty flags and synchronous flush. It is the same-domain successor to our dual-clock pointer FIFO: it keeps the valid/ready interfaces but drops gray-code synchronisation. It adds status outputs for rate-matching stages inside one clock domain, such as line buffers and pixel pipelines. An optional bypass path gives zero-latency pass-through when the FIFO is empty.

## Interface
- width_p, 32, data width in bits (≥1)
- depth_log2_p, 4, log2 of storage depth; depth = 2^depth_log2_p (≥1)
- almost_full_p, 2^depth_log2_p-1, almost_full_o asserts when count ≥ this value (1..depth)
- almost_empty_p, 1, almost_empty_o asserts when count ≤ this value (0..depth-1)

- clk_i  in  1  clock; all logic on posedge
- reset_ni  in  1  reset; one clock, synchronous, active-low
- flush_i  in  1  synchronous clear of contents
- cdata_i  in  width_p  write data
- cvalid_i  in  1  write request
- cready_o  out  1  FIFO can accept (not full, not flushing)
- pvalid_o  out  1  read data available
- pdata_o  out  width_p  read data
- pready_i  in  1  downstream accepts
- count_o  out  depth_log2_p+1  current occupancy, 0..depth
- almost_full_o  out  1  count_o ≥ almost_full_p
- almost_empty_o  out  1  count_o ≤ almost_empty_p

## Operation
- Push = cvalid_i & cready_o. Pop = pvalid_o & pready_i. Each transfers exactly one word.
- Write pointer and read pointer are depth_log2_p+1 bits and increment on push/pop, wrapping modulo 2^(depth_log2_p+1). Memory is addressed by the low depth_log2_p bits.
- Full: MSBs differ and low bits are equal. Empty: pointers are equal. count_o = wr_ptr − rd_ptr, truncated to depth_log2_p+1 bits.
- cready_o = ~full & ~flush_i. A pop in the same cycle does not open a slot while full; there is no combinational pready_i→cready_o path.
- pvalid_o = ~empty & ~flush_i (plus the bypass term, see Configuration).
- Simultaneous push and pop when 0 < count < depth: count unchanged, both pointers advance.
- pdata_o always presents the word at rd_ptr, including when a push and pop hit the same address in the same cycle. Memory is a registered read array fed with the next read pointer. A write to the address being read in that cycle forwards write data to the output register.
- flush_i: at the next edge, both pointers become 0. flush_i has priority over push/pop, and no transfer occurs in a flush cycle.
- almost_full_o and almost_empty_o are compares on the registered count.

## Timing
- While reset_ni = 0 at an edge: pointers = 0 and output register = 0. After that edge: cready_o = 1, pvalid_o = 0, pdata_o = 0, count_o = 0, almost_empty_o = 1, almost_full_o = 0.
- Reset asserted mid-operation discards contents at that edge, identical to flush. Reset has priority over flush_i.
- Without bypass, write-to-read latency is 1 cycle: a push at edge N gives pvalid_o = 1 and valid pdata_o in the cycle after N.
- Pop throughput is 1 word/cycle sustained. count_o and the flags update the cycle after the causing edge.

## Configuration
- FIFO_SYNC_BYPASS_EN defined: when count_o = 0 and cvalid_i = 1 (no flush), pvalid_o = 1 and pdata_o = cdata_i combinationally.
  - If pready_i = 1 in that cycle, the word passes through unstored; pointers and count are unchanged.
  - If pready_i = 0, the word is stored normally.
  - Latency is 0 cycles when empty.
- FIFO_SYNC_BYPASS_EN undefined: no combinational path from the write side to the read side; latency is always 1 cycle.

## Test plan
Configuration for all scenarios: width_p = 8, depth_log2_p = 2 (depth 4), almost_full_p = 3, almost_empty_p = 1.
- Reset: hold reset_ni = 0 for 2 cycles → cready_o = 1, pvalid_o = 0, count_o = 0, almost_empty_o = 1, pdata_o = 0.
- Fill: push 0x11, 0x22, 0x33, 0x44 with pready_i = 0 → count_o steps 1, 2, 3, 4. almost_full_o rises at count 3; cready_o = 0 at count 4. A fifth push with 0x55 is refused.
- Drain with wrap: from full, pop 2 words, push 0x55, 0x66, then pop everything → output order 0x11, 0x22, 0x33, 0x44, 0x55, 0x66. Then pvalid_o = 0 and count_o = 0.
- Full with pready_i = 1: at count 4 with cvalid_i = 1 → one pop only, count_o = 3 next cycle, cready_o = 1.
- Simultaneous push/pop at count 1 (same address boundary): stream 0xA0..0xAF with pready_i = 1 → outputs in order with no duplicate or stale word. Count stays 1 without bypass, or 0 with bypass.
- Flush: at count 3, assert flush_i together with cvalid_i = 1 and pready_i = 1 → no transfer. Next cycle count_o = 0, pvalid_o = 0. A following push 0x77 is read back as 0x77.
